// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and empty/occupancy status for the asynchronous FIFO.
// Consumes the synchronized Gray write pointer and produces the Gray read pointer for the write side.
module rptr_empty_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rstn,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE:0]   rdq2_wptr,
    input  logic                 underflow_clr,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic [ADDR_SIZE:0]   rd_ptr,
    output logic                 rd_empty,
    output logic                 rd_almost_empty,
    output logic [ADDR_SIZE:0]   rd_count,
    output logic                 rd_valid,
    output logic                 rd_underflow
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] occ_next;
    logic          rinc;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(rdq2_wptr >> i);
        end
    end

    always_comb begin
        rinc      = rd_en & ~rd_empty;
        rbin_next = rbin + {{ADDR_SIZE{1'b0}}, rinc};
        gray_next = (rbin_next >> 1) ^ rbin_next;
        occ_next  = wbin - rbin_next;
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rbin            <= '0;
            rd_ptr          <= '0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_count        <= '0;
            rd_valid        <= 1'b0;
            rd_underflow    <= 1'b0;
        end else begin
            rbin            <= rbin_next;
            rd_ptr          <= gray_next;
            rd_empty        <= (gray_next == rdq2_wptr);
            rd_count        <= occ_next;
            rd_almost_empty <= (occ_next <= AE_THR);
            rd_valid        <= rinc;
            // A new underflow in the same cycle as a clear must not be lost.
            if (rd_en && rd_empty) begin
                rd_underflow <= 1'b1;
            end else if (underflow_clr) begin
                rd_underflow <= 1'b0;
            end
        end
    end

    assign rd_addr = rbin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Directed and randomized bench for rptr_empty_ctrl; model tracks total reads/writes as plain integers.
module tb_rptr_empty_ctrl;

    localparam int AS    = 4;
    localparam int DEPTH = 1 << AS;
    localparam int AE    = 2;

    logic          rd_clk = 1'b0;
    logic          rd_rstn;
    logic          rd_en;
    logic [AS:0]   rdq2_wptr;
    logic          underflow_clr;
    logic [AS-1:0] rd_addr;
    logic [AS:0]   rd_ptr;
    logic          rd_empty;
    logic          rd_almost_empty;
    logic [AS:0]   rd_count;
    logic          rd_valid;
    logic          rd_underflow;

    rptr_empty_ctrl #(.ADDR_SIZE(AS), .AE_LEVEL(AE)) dut (
        .rd_clk          (rd_clk),
        .rd_rstn         (rd_rstn),
        .rd_en           (rd_en),
        .rdq2_wptr       (rdq2_wptr),
        .underflow_clr   (underflow_clr),
        .rd_addr         (rd_addr),
        .rd_ptr          (rd_ptr),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_count        (rd_count),
        .rd_valid        (rd_valid),
        .rd_underflow    (rd_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: running totals of words written (as seen after sync) and words read.
    int m_wcnt, m_rcnt;
    bit m_uf, m_valid;

    function automatic logic [AS:0] to_gray(input int n);
        int b;
        b = n % (2 * DEPTH);
        return (AS+1)'(b ^ (b / 2));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        int occ;
        occ = m_wcnt - m_rcnt;
        check({where, ":count"}, 32'(rd_count), 32'(occ));
        check({where, ":empty"}, 32'(rd_empty), 32'(occ == 0));
        check({where, ":aempty"}, 32'(rd_almost_empty), 32'(occ <= AE));
        check({where, ":ptr"}, 32'(rd_ptr), 32'(to_gray(m_rcnt)));
        check({where, ":addr"}, 32'(rd_addr), 32'(m_rcnt % DEPTH));
        check({where, ":valid"}, 32'(rd_valid), 32'(m_valid));
        check({where, ":uflow"}, 32'(rd_underflow), 32'(m_uf));
    endtask

    task automatic model_reset();
        m_wcnt = 0; m_rcnt = 0; m_uf = 0; m_valid = 0;
    endtask

    // One clock: apply inputs, advance the model for the coming edge, sample 1 ns after it.
    task automatic step(input bit en, input int wadd, input bit clr, input string where);
        bit empty_before;
        empty_before  = (m_wcnt == m_rcnt);
        m_wcnt        = m_wcnt + wadd;
        rd_en         = en;
        underflow_clr = clr;
        rdq2_wptr     = to_gray(m_wcnt);
        @(posedge rd_clk);
        #1;
        m_valid = en && !empty_before;
        if (m_valid) m_rcnt++;
        if (en && empty_before) m_uf = 1;
        else if (clr) m_uf = 0;
        check_all(where);
    endtask

    initial begin
        model_reset();
        rd_rstn       = 1'b0;
        rd_en         = 1'b1;
        underflow_clr = 1'b0;
        rdq2_wptr     = (AS+1)'($urandom);
        repeat (3) @(posedge rd_clk);
        #1;
        check_all("reset");
        rdq2_wptr = (AS+1)'($urandom);
        #2;
        check_all("reset_w");

        rd_en     = 1'b0;
        rdq2_wptr = '0;
        @(negedge rd_clk);
        rd_rstn = 1'b1;

        // Single entry appears, then is read out.
        step(0, 1, 0, "single_wr");
        step(1, 0, 0, "single_rd");
        step(0, 0, 0, "single_idle");

        // Underflow: set, set-beats-clear, then clear alone.
        step(1, 0, 0, "uf_set");
        step(1, 0, 1, "uf_setclr");
        step(0, 0, 1, "uf_clr");

        // Full drains, twice, so the read pointer passes through its wrap.
        for (int pass = 0; pass < 2; pass++) begin
            step(0, DEPTH, 0, "fill");
            for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, "drain");
        end

        // Writer stays one ahead of the reader.
        step(0, 1, 0, "conc_prime");
        for (int i = 0; i < 20; i++) step(1, 1, 0, "conc");

        // Asynchronous reset in the middle of a cycle with data pending.
        step(0, 7, 0, "pre_rst");
        #2;
        rd_rstn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        rdq2_wptr = '0;
        rd_en     = 1'b1;
        @(negedge rd_clk);
        rd_rstn = 1'b1;
        step(1, 0, 0, "post_rst");
        step(1, 0, 0, "post_rst2");

        // Randomized traffic with occupancy kept legal.
        for (int i = 0; i < 600; i++) begin
            int wadd;
            int room;
            room = DEPTH - (m_wcnt - m_rcnt);
            wadd = 0;
            if ($urandom_range(0, 9) < 4) wadd = 1;
            if ($urandom_range(0, 39) == 0) wadd = $urandom_range(0, DEPTH);
            if (wadd > room) wadd = room;
            step(bit'($urandom_range(0, 9) < 5), wadd, bit'($urandom_range(0, 7) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
